// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_lite_pkg : response codes, register map and CTRL bit layout
// Revision     : 1.0
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [4:0] OFF_CTRL        = 5'h00;
    localparam logic [4:0] OFF_SCRATCH     = 5'h04;
    localparam logic [4:0] OFF_STATUS      = 5'h08;
    localparam logic [4:0] OFF_IRQ_STATUS  = 5'h0C;
    localparam logic [4:0] OFF_IRQ_MASK    = 5'h10;
    localparam logic [4:0] OFF_TIMER_LOAD  = 5'h14;
    localparam logic [4:0] OFF_TIMER_VALUE = 5'h18;
    localparam logic [4:0] OFF_VERSION     = 5'h1C;

    localparam int CTRL_TIMER_EN = 0;
    localparam int CTRL_IRQ_EN   = 1;

    // Word index within the window, i.e. offset[4:2]
    typedef enum logic [2:0] {
        REG_CTRL        = 3'd0,
        REG_SCRATCH     = 3'd1,
        REG_STATUS      = 3'd2,
        REG_IRQ_STATUS  = 3'd3,
        REG_IRQ_MASK    = 3'd4,
        REG_TIMER_LOAD  = 3'd5,
        REG_TIMER_VALUE = 3'd6,
        REG_VERSION     = 3'd7
    } reg_idx_e;

    function automatic logic reg_is_ro(input reg_idx_e idx);
        return (idx == REG_STATUS) || (idx == REG_TIMER_VALUE) || (idx == REG_VERSION);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_timer : reloadable down-counter, expiry pulse when enabled at zero
// Revision      : 1.0
// ---------------------------------------------------------------------------
module regfile_timer #(
    parameter int WIDTH = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             enable,
    input  logic             start,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             expiry
);

    // The load cycle itself never counts as an expiry
    assign expiry = enable & ~start & (value == '0);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            value <= '0;
        end else if (start) begin
            value <= load_value;
        end else if (enable) begin
            if (value == '0) begin
                value <= load_value;
            end else begin
                value <= value - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_lite_regfile : control/status registers, W1C interrupt block and timer
// Revision         : 1.0
// ---------------------------------------------------------------------------
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter int                    EVT_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] VERSION    = 32'h0001_0000
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   user_wr_addr,
    input  logic [DATA_WIDTH-1:0]   user_wr_data,
    input  logic [DATA_WIDTH/8-1:0] user_wr_strb,
    input  logic                    user_wr_en,
    output logic [1:0]              user_wr_resp,
    input  logic [ADDR_WIDTH-1:0]   user_rd_addr,
    input  logic                    user_rd_en,
    output logic [DATA_WIDTH-1:0]   user_rd_data,
    output logic [1:0]              user_rd_resp,
    input  logic [DATA_WIDTH-1:0]   status_in,
    input  logic [EVT_WIDTH-1:0]    event_in,
    output logic [DATA_WIDTH-1:0]   ctrl_out,
    output logic                    irq
);

    localparam logic [DATA_WIDTH-1:0] IRQ_VALID =
        DATA_WIDTH'((64'd1 << (EVT_WIDTH + 1)) - 64'd1);

    logic [DATA_WIDTH-1:0] ctrl_q, scratch_q, irq_status_q, irq_mask_q, timer_load_q;
    logic [DATA_WIDTH-1:0] ctrl_d, scratch_d, irq_status_d, irq_mask_d, timer_load_d;
    logic                  irq_q;

    logic [ADDR_WIDTH-1:0] wr_off, rd_off;
    reg_idx_e              wr_idx, rd_idx;
    logic                  wr_ok, rd_ok, wr_commit;
    logic [DATA_WIDTH-1:0] wmask, irq_clr, irq_set, rd_mux;
    logic [DATA_WIDTH-1:0] timer_value;
    logic                  timer_expiry, timer_start;

    // Reads are side-effect free and responses are address-only, so rd_en is not needed
    logic unused_rd_en;
    assign unused_rd_en = user_rd_en;

    // Subtraction wraps addresses below BASE_ADDR out of the window
    assign wr_off = user_wr_addr - BASE_ADDR;
    assign rd_off = user_rd_addr - BASE_ADDR;
    assign wr_idx = reg_idx_e'(wr_off[4:2]);
    assign rd_idx = reg_idx_e'(rd_off[4:2]);

    assign wr_ok = (wr_off[ADDR_WIDTH-1:5] == '0) && (wr_off[1:0] == 2'b00) && !reg_is_ro(wr_idx);
    assign rd_ok = (rd_off[ADDR_WIDTH-1:5] == '0) && (rd_off[1:0] == 2'b00);

    assign user_wr_resp = wr_ok ? RESP_OKAY : RESP_SLVERR;
    assign user_rd_resp = rd_ok ? RESP_OKAY : RESP_SLVERR;
    assign wr_commit    = user_wr_en & wr_ok;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            wmask[b*8 +: 8] = {8{user_wr_strb[b]}};
        end
    end

    always_comb begin
        ctrl_d       = ctrl_q;
        scratch_d    = scratch_q;
        irq_mask_d   = irq_mask_q;
        timer_load_d = timer_load_q;
        irq_clr      = '0;
        if (wr_commit) begin
            case (wr_idx)
                REG_CTRL:       ctrl_d       = (ctrl_q       & ~wmask) | (user_wr_data & wmask);
                REG_SCRATCH:    scratch_d    = (scratch_q    & ~wmask) | (user_wr_data & wmask);
                REG_IRQ_MASK:   irq_mask_d   = (irq_mask_q   & ~wmask) | (user_wr_data & wmask);
                REG_TIMER_LOAD: timer_load_d = (timer_load_q & ~wmask) | (user_wr_data & wmask);
                REG_IRQ_STATUS: irq_clr      = user_wr_data & wmask;
                default:        ;
            endcase
        end
    end

    always_comb begin
        irq_set              = '0;
        irq_set[EVT_WIDTH:1] = event_in;
        irq_set[0]           = timer_expiry;
        // Set is applied after clear so a simultaneous event wins
        irq_status_d         = ((irq_status_q & ~irq_clr) | irq_set) & IRQ_VALID;
    end

    assign timer_start = ctrl_d[CTRL_TIMER_EN] & ~ctrl_q[CTRL_TIMER_EN];

    regfile_timer #(
        .WIDTH      (DATA_WIDTH)
    ) u_timer (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .enable     (ctrl_q[CTRL_TIMER_EN]),
        .start      (timer_start),
        .load_value (timer_load_q),
        .value      (timer_value),
        .expiry     (timer_expiry)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl_q       <= '0;
            scratch_q    <= '0;
            irq_status_q <= '0;
            irq_mask_q   <= '0;
            timer_load_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            scratch_q    <= scratch_d;
            irq_status_q <= irq_status_d;
            irq_mask_q   <= irq_mask_d;
            timer_load_q <= timer_load_d;
            irq_q        <= ctrl_q[CTRL_IRQ_EN] & (|(irq_status_q & irq_mask_q));
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            REG_CTRL:        rd_mux = ctrl_q;
            REG_SCRATCH:     rd_mux = scratch_q;
            REG_STATUS:      rd_mux = status_in;
            REG_IRQ_STATUS:  rd_mux = irq_status_q;
            REG_IRQ_MASK:    rd_mux = irq_mask_q;
            REG_TIMER_LOAD:  rd_mux = timer_load_q;
            REG_TIMER_VALUE: rd_mux = timer_value;
            REG_VERSION:     rd_mux = VERSION;
            default:         rd_mux = '0;
        endcase
    end

    assign user_rd_data = rd_ok ? rd_mux : '0;
    assign ctrl_out     = ctrl_q;
    assign irq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi_lite_regfile : vector table plus scoreboard bench for axi_lite_regfile
// Revision            : 1.0
// ---------------------------------------------------------------------------
module tb_axi_lite_regfile;
    import axi_lite_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data, status_in, ctrl_out;
    logic [3:0]  wr_strb;
    logic        wr_en, rd_en, irq;
    logic [1:0]  wr_resp, rd_resp;
    logic [7:0]  event_in;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] status;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        bit          chk_irq;
        bit          irq;
    } sb_ent_t;

    vec_t    vecs[$];
    sb_ent_t sb[$];
    sb_ent_t mon_e;

    axi_lite_regfile dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .user_wr_addr (wr_addr),
        .user_wr_data (wr_data),
        .user_wr_strb (wr_strb),
        .user_wr_en   (wr_en),
        .user_wr_resp (wr_resp),
        .user_rd_addr (rd_addr),
        .user_rd_en   (rd_en),
        .user_rd_data (rd_data),
        .user_rd_resp (rd_resp),
        .status_in    (status_in),
        .event_in     (event_in),
        .ctrl_out     (ctrl_out),
        .irq          (irq)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] st,
                                input logic [31:0] ed, input logic [1:0] er);
        vec_t v;
        v.is_wr = w; v.addr = a; v.data = d; v.strb = s;
        v.status = st; v.exp_data = ed; v.exp_resp = er;
        return v;
    endfunction

    // Each access task starts just after a rising edge and returns just after the next one
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] er);
        sb_ent_t e;
        e.is_wr = 1'b1; e.addr = a; e.data = '0; e.resp = er; e.chk_irq = 1'b0; e.irq = 1'b0;
        wr_addr = a; wr_data = d; wr_strb = s; wr_en = 1'b1;
        sb.push_back(e);
        @(posedge aclk);
        #1 wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                           input bit ci, input bit ei);
        sb_ent_t e;
        e.is_wr = 1'b0; e.addr = a; e.data = ed; e.resp = er; e.chk_irq = ci; e.irq = ei;
        rd_addr = a; rd_en = 1'b1;
        sb.push_back(e);
        @(posedge aclk);
        #1 rd_en = 1'b0;
    endtask

    task automatic check_irq(input bit ei);
        @(negedge aclk);
        chk("irq", {31'b0, irq}, {31'b0, ei});
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_event(input logic [7:0] ev);
        event_in = ev;
        @(posedge aclk);
        #1 event_in = '0;
    endtask

    always @(negedge aclk) begin
        if (wr_en || rd_en) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got access with empty queue expected queued entry");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_wr) begin
                    chk($sformatf("wr_resp@%h", mon_e.addr), {30'b0, wr_resp}, {30'b0, mon_e.resp});
                end else begin
                    chk($sformatf("rd_data@%h", mon_e.addr), rd_data, mon_e.data);
                    chk($sformatf("rd_resp@%h", mon_e.addr), {30'b0, rd_resp}, {30'b0, mon_e.resp});
                end
                if (mon_e.chk_irq)
                    chk($sformatf("irq@%h", mon_e.addr), {31'b0, irq}, {31'b0, mon_e.irq});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0; wr_en = 1'b0;
        rd_addr = '0; rd_en = 1'b0; status_in = '0; event_in = '0;

        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 32'(i*4), '0, 4'h0, '0, (i == 7) ? 32'h0001_0000 : 32'h0, RESP_OKAY));
        vecs.push_back(mk(1, 32'(OFF_SCRATCH), 32'hAABB_CCDD, 4'hF, '0, '0, RESP_OKAY));
        vecs.push_back(mk(1, 32'(OFF_SCRATCH), 32'h1122_3344, 4'h5, '0, '0, RESP_OKAY));
        vecs.push_back(mk(0, 32'(OFF_SCRATCH), '0, 4'h0, '0, 32'hAA22_CC44, RESP_OKAY));
        vecs.push_back(mk(1, 32'(OFF_STATUS), 32'hFFFF_FFFF, 4'hF, 32'h1357_9BDF, '0, RESP_SLVERR));
        vecs.push_back(mk(0, 32'(OFF_STATUS), '0, 4'h0, 32'h1357_9BDF, 32'h1357_9BDF, RESP_OKAY));
        vecs.push_back(mk(0, 32'h20, '0, 4'h0, '0, '0, RESP_SLVERR));
        vecs.push_back(mk(0, 32'h02, '0, 4'h0, '0, '0, RESP_SLVERR));
        vecs.push_back(mk(1, 32'(OFF_TIMER_VALUE), 32'h1, 4'hF, '0, '0, RESP_SLVERR));
        vecs.push_back(mk(1, 32'(OFF_VERSION), 32'h0, 4'hF, '0, '0, RESP_SLVERR));
        vecs.push_back(mk(0, 32'(OFF_VERSION), '0, 4'h0, '0, 32'h0001_0000, RESP_OKAY));
        vecs.push_back(mk(1, 32'h05, 32'hFFFF_FFFF, 4'hF, '0, '0, RESP_SLVERR));
        vecs.push_back(mk(1, 32'h24, 32'hFFFF_FFFF, 4'hF, '0, '0, RESP_SLVERR));
        vecs.push_back(mk(0, 32'(OFF_SCRATCH), '0, 4'h0, '0, 32'hAA22_CC44, RESP_OKAY));
        vecs.push_back(mk(1, 32'(OFF_CTRL), 32'h5555_55F0, 4'h1, '0, '0, RESP_OKAY));
        vecs.push_back(mk(0, 32'(OFF_CTRL), '0, 4'h0, '0, 32'h0000_00F0, RESP_OKAY));
        vecs.push_back(mk(1, 32'(OFF_CTRL), 32'h0, 4'hF, '0, '0, RESP_OKAY));
        vecs.push_back(mk(0, 32'(OFF_TIMER_VALUE), '0, 4'h0, '0, 32'h0, RESP_OKAY));
        vecs.push_back(mk(1, 32'(OFF_IRQ_STATUS), 32'hFFFF_FFFF, 4'hF, '0, '0, RESP_OKAY));
        vecs.push_back(mk(0, 32'(OFF_IRQ_STATUS), '0, 4'h0, '0, 32'h0, RESP_OKAY));

        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_ctrl_out", ctrl_out, 32'h0);

        foreach (vecs[i]) begin
            status_in = vecs[i].status;
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
            else
                do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, 1'b0, 1'b0);
        end

        // Event path: set, W1C clear, then set and clear together
        do_write(32'(OFF_IRQ_MASK), 32'h8, 4'hF, RESP_OKAY);
        do_write(32'(OFF_CTRL), 32'h2, 4'hF, RESP_OKAY);
        chk("ctrl_out", ctrl_out, 32'h2);
        pulse_event(8'h04);
        check_irq(1'b0);
        do_read(32'(OFF_IRQ_STATUS), 32'h8, RESP_OKAY, 1'b1, 1'b1);
        do_write(32'(OFF_IRQ_STATUS), 32'h8, 4'hF, RESP_OKAY);
        do_read(32'(OFF_IRQ_STATUS), 32'h0, RESP_OKAY, 1'b1, 1'b1);
        do_read(32'(OFF_IRQ_STATUS), 32'h0, RESP_OKAY, 1'b1, 1'b0);
        event_in = 8'h04;
        do_write(32'(OFF_IRQ_STATUS), 32'h8, 4'hF, RESP_OKAY);
        event_in = '0;
        do_read(32'(OFF_IRQ_STATUS), 32'h8, RESP_OKAY, 1'b1, 1'b0);
        check_irq(1'b1);
        do_write(32'(OFF_IRQ_STATUS), 32'h8, 4'hF, RESP_OKAY);
        do_read(32'(OFF_IRQ_STATUS), 32'h0, RESP_OKAY, 1'b1, 1'b1);
        do_read(32'(OFF_IRQ_STATUS), 32'h0, RESP_OKAY, 1'b1, 1'b0);

        // Timer: LOAD=3 gives 3,2,1,0,3,...; expiry at the fourth edge, irq one edge later
        do_write(32'(OFF_TIMER_LOAD), 32'h3, 4'hF, RESP_OKAY);
        do_write(32'(OFF_IRQ_MASK), 32'h1, 4'hF, RESP_OKAY);
        do_write(32'(OFF_CTRL), 32'h3, 4'hF, RESP_OKAY);
        for (int k = 0; k < 7; k++)
            do_read(32'(OFF_TIMER_VALUE), 32'(3 - (k % 4)), RESP_OKAY, 1'b1, (k >= 5));
        do_read(32'(OFF_IRQ_STATUS), 32'h1, RESP_OKAY, 1'b1, 1'b1);

        // Asynchronous reset while running
        aresetn = 1'b0;
        #1;
        chk("arst_ctrl_out", ctrl_out, 32'h0);
        chk("arst_irq", {31'b0, irq}, 32'h0);
        rd_addr = 32'(OFF_TIMER_VALUE);
        #1 chk("arst_timer_value", rd_data, 32'h0);
        rd_addr = 32'(OFF_IRQ_STATUS);
        #1 chk("arst_irq_status", rd_data, 32'h0);
        @(posedge aclk);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (4) @(posedge aclk);
        #1;
        do_read(32'(OFF_TIMER_VALUE), 32'h0, RESP_OKAY, 1'b1, 1'b0);
        do_read(32'(OFF_CTRL), 32'h0, RESP_OKAY, 1'b1, 1'b0);
        do_read(32'(OFF_IRQ_STATUS), 32'h0, RESP_OKAY, 1'b1, 1'b0);
        do_read(32'(OFF_TIMER_VALUE), 32'h0, RESP_OKAY, 1'b1, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
Register file that consumes the simplified local bus produced by the AXI-Lite slave controller (user_wr_* / user_rd_*). It holds the control and status registers, a sticky write-1-to-clear interrupt block and a reloadable down-counter timer. It returns read data and OKAY/SLVERR responses on that bus and drives control/interrupt outputs to the datapath.

Parameters:
ADDR_WIDTH, 32, local bus address width
DATA_WIDTH, 32, data width; only 32 is supported
BASE_ADDR, 32'h0000_0000, byte base address of the 32-byte register window
EVT_WIDTH, 8, number of external event inputs (1..31)
VERSION, 32'h0001_0000, value returned by the VERSION register

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
user_wr_addr  in  ADDR_WIDTH  write byte address, stable while a response is pending
user_wr_data  in  DATA_WIDTH  write data
user_wr_strb  in  DATA_WIDTH/8  byte strobes
user_wr_en  in  1  1-cycle write commit pulse
user_wr_resp  out  2  write response, combinational
user_rd_addr  in  ADDR_WIDTH  read byte address
user_rd_en  in  1  1-cycle read pulse
user_rd_data  out  DATA_WIDTH  read data, combinational
user_rd_resp  out  2  read response, combinational
status_in  in  DATA_WIDTH  live status, mirrored into STATUS
event_in  in  EVT_WIDTH  event pulses, sampled every cycle
ctrl_out  out  DATA_WIDTH  CTRL register contents
irq  out  1  level interrupt

Behaviour:
- Reset and clocking: aclk, aresetn asynchronous active-low. All registers, the timer and irq reset to 0.
- Register map (offset from BASE_ADDR):
  - 0x00 CTRL, RW. bit0 = timer enable, bit1 = global irq enable, other bits are free for the datapath.
  - 0x04 SCRATCH, RW.
  - 0x08 STATUS, RO, equals status_in.
  - 0x0C IRQ_STATUS, W1C. bit0 = timer expiry, bits[EVT_WIDTH:1] = events, other bits read 0.
  - 0x10 IRQ_MASK, RW.
  - 0x14 TIMER_LOAD, RW.
  - 0x18 TIMER_VALUE, RO.
  - 0x1C VERSION, RO.
- Decode is purely combinational from the address inputs. Responses:
  - Address outside [BASE_ADDR, BASE_ADDR+0x1F] -> SLVERR (2'b10).
  - addr[1:0] != 0 -> SLVERR.
  - Write to an RO register -> SLVERR.
  - Otherwise OKAY (2'b00).
- Responses hold for as long as the address input is stable. They do not depend on wr_en or rd_en, because the upstream block forwards them during its response phase.
- Writes take effect on the aclk edge where user_wr_en = 1 and the response is OKAY; any other write has no effect.
  - RW registers: byte n is updated only if strb[n] = 1.
  - W1C: bits clear where (wdata & byte-mask) = 1.
- Reads: user_rd_data is valid in the same cycle as user_rd_en with zero latency. Error addresses read 0. Reads have no side effects.
- IRQ_STATUS set sources:
  - bit i+1 sets on any cycle with event_in[i] = 1.
  - bit0 sets on timer expiry.
  - Set and W1C clear of the same bit in the same cycle: set wins, bit stays 1.
- irq is registered: irq <= CTRL[1] & |(IRQ_STATUS & IRQ_MASK). It therefore lags the status change by one cycle.
- Timer:
  - CTRL[0] written 0->1 loads TIMER_VALUE from TIMER_LOAD. That cycle is not an expiry.
  - While enabled:
    - Value 0 -> reload TIMER_LOAD and pulse expiry.
    - Otherwise decrement by 1. Period = TIMER_LOAD+1 cycles; LOAD = 0 expires every cycle.
  - While disabled: value holds.
  - A TIMER_LOAD write while running affects only the next reload.
- Mid-operation reset: all state returns to reset values immediately. No pending write completes after reset is released.

Decomposition:
- Shared package axi_lite_pkg:
  - Response codes RESP_OKAY / RESP_SLVERR.
  - Register offset constants.
  - CTRL bit indices.
- One sub-module, regfile_timer: load/enable/expiry down-counter. All other logic stays in the top block.

Test Plan:
1. Reset, then read all 8 offsets -> VERSION = 32'h0001_0000, every other register 0, all responses OKAY, irq = 0.
2. SCRATCH partial write: write 0xAABBCCDD with strb 4'b1111, then 0x11223344 with strb 4'b0101 -> SCRATCH reads 0xAA22CC44.
3. Error responses:
   - Write to 0x08 -> SLVERR, STATUS unaffected.
   - Read at 0x20 -> SLVERR, data 0.
   - Read at 0x02 -> SLVERR.
4. Event and interrupt path:
   - Pulse event_in[2] with IRQ_MASK = 0x8 and CTRL = 0x2 -> IRQ_STATUS = 0x8, irq high one cycle later.
   - Write 0x8 to IRQ_STATUS -> cleared, irq low.
   - Repeat with the event and the W1C in the same cycle -> bit remains 1.
5. Timer: TIMER_LOAD = 3, CTRL = 0x3, IRQ_MASK = 1 -> TIMER_VALUE sequence 3,2,1,0,3..., IRQ_STATUS[0] set exactly 4 cycles after enable, irq follows next cycle.
6. Assert aresetn low while the timer is running and IRQ_STATUS is nonzero -> CTRL, TIMER_VALUE, IRQ_STATUS and irq are 0 immediately, and the timer stays stopped after reset is released.
